// File: rtl/dmem_resp.sv
// Single-port data memory responder with fixed request-to-response latency and RV32I byte/half/word lanes.
// Optional macro DMEM_RESP_ERR_EN enables access-fault detection on rsp_err.
module dmem_resp #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                vld_q, vld_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                enter_resp;
  logic                wr_en;
  logic                a_we;
  logic [2:0]          a_f3;
  logic [AWIDTH-1:0]   a_addr;
  logic [DWIDTH-1:0]   a_wdata;
  logic [IW-1:0]       idx;
  logic [AWIDTH-3:0]   widx_full;
  logic                illegal, misalign, oor, fault;
  logic                is_b, is_h;
  logic [3:0]          be;
  logic [31:0]         wlane;
  logic [31:0]         rd_word;
  logic [7:0]          bsel;
  logic [15:0]         hsel;
  logic [DWIDTH-1:0]   ld_val;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY=1 the commit edge is the accept edge, so the access is decoded from the live request.
  assign a_we    = (state_q == S_IDLE) ? req_we     : we_q;
  assign a_f3    = (state_q == S_IDLE) ? req_funct3 : f3_q;
  assign a_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;

  assign idx       = a_addr[IW+1:2];
  assign widx_full = a_addr[AWIDTH-1:2];
  assign illegal   = a_we ? (a_f3 >= 3'b011) : ((a_f3 == 3'b011) || (a_f3[2:1] == 2'b11));
  assign misalign  = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                     ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
  assign oor       = widx_full >= (AWIDTH-2)'(DEPTH);
  assign is_b      = !illegal && (a_f3[1:0] == 2'b00);
  assign is_h      = !illegal && (a_f3[1:0] == 2'b01);

`ifdef DMEM_RESP_ERR_EN
  assign fault = illegal || misalign || oor;
`else
  logic unused_fault_bits;
  assign fault             = 1'b0;
  assign unused_fault_bits = misalign ^ oor;
`endif

  always_comb begin
    be    = 4'b0000;
    wlane = a_wdata;
    if (is_b) begin
      be[a_addr[1:0]] = 1'b1;
      wlane           = {4{a_wdata[7:0]}};
    end else if (is_h) begin
      be    = a_addr[1] ? 4'b1100 : 4'b0011;
      wlane = {2{a_wdata[15:0]}};
    end else begin
      be = 4'b1111;
    end
  end

  assign rd_word = mem[idx];

  always_comb begin
    case (a_addr[1:0])
      2'd0:    bsel = rd_word[7:0];
      2'd1:    bsel = rd_word[15:8];
      2'd2:    bsel = rd_word[23:16];
      default: bsel = rd_word[31:24];
    endcase
    hsel = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    if (is_b) begin
      ld_val = {{24{bsel[7] & ~a_f3[2]}}, bsel};
    end else if (is_h) begin
      ld_val = {{16{hsel[15] & ~a_f3[2]}}, hsel};
    end else begin
      ld_val = rd_word;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    vld_d      = (state_d == S_RESP);
    wr_en      = enter_resp && a_we && !fault;
    if (enter_resp) begin
      rdata_d = (a_we || fault) ? '0 : ld_val;
      err_d   = fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array holds no reset; a store reset mid-flight never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wlane[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: LATENCY=2 instance for function/stall/reset, LATENCY=3 instance for streaming.
module tb_dmem_resp;

`ifdef DMEM_RESP_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        s_req_valid = 1'b0, s_req_we = 1'b0, s_rsp_ready = 1'b0;
  logic [2:0]  s_req_funct3 = 3'b010;
  logic [31:0] s_req_addr = '0, s_req_wdata = '0;
  logic        s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_resp #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_resp #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Edge count includes the accept edge; rsp_valid must be seen after exactly LATENCY edges.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
    int n;
    check({tag, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'd2);
  endtask

  task automatic retire(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    issue(we, f3, a, wd, tag);
    check({tag, ".rd"}, rsp_rdata, exp_rd);
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    retire(tag);
  endtask

  logic        st_we [6];
  logic [31:0] st_addr [6];
  logic [31:0] st_wd [6];
  logic [31:0] st_exp [6];

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst.rdy", 32'(req_ready), 32'd0);
    check("rst.vld", 32'(rsp_valid), 32'd0);
    check("rst.rd",  rsp_rdata, 32'd0);
    check("rst.err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
    txn(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, "sw10z");
    txn(1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0, "sb13");
    txn(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb13");
    txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu13");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0, "lw10b");
    txn(1'b1, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0, "sw14z");
    txn(1'b1, 3'b001, 32'h16, 32'h0000A5B6, 32'h0, 1'b0, "sh16");
    txn(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFFA5B6, 1'b0, "lh16");
    txn(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000A5B6, 1'b0, "lhu16");
    txn(1'b0, 3'b010, 32'h14, 32'h0, 32'hA5B60000, 1'b0, "lw14");
    txn(1'b1, 3'b010, 32'h0, 32'h11223344, 32'h0, 1'b0, "sw0");
    txn(1'b0, 3'b000, 32'h1, 32'h0, 32'h00000033, 1'b0, "lb1");
    txn(1'b0, 3'b001, 32'h2, 32'h0, 32'h00001122, 1'b0, "lh2");
    txn(1'b0, 3'b010, 32'h2, 32'h0, ERR ? 32'h0 : 32'h11223344, ERR, "lw2mis");
    txn(1'b0, 3'b011, 32'h0, 32'h0, ERR ? 32'h0 : 32'h11223344, ERR, "ld011");
    txn(1'b1, 3'b011, 32'h0, 32'h11223344, 32'h0, ERR, "st011");
    txn(1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0, "lw0");
    txn(1'b0, 3'b010, 32'h1000, 32'h0, ERR ? 32'h0 : 32'h11223344, ERR, "lwoor");

    // Response held back while a competing request waits.
    issue(1'b0, 3'b010, 32'h10, 32'h0, "stall");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55555555; req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall.vld", 32'(rsp_valid), 32'd1);
      check("stall.rd",  rsp_rdata, 32'h80000000);
      check("stall.rdy", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    retire("stall");
    repeat (3) @(posedge clk);
    #1;
    check("stall.nospur", 32'(rsp_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0, "stall.mem");

    // Reset during WAIT of a store drops it.
    txn(1'b1, 3'b010, 32'h20, 32'hCAFE0001, 32'h0, 1'b0, "sw20");
    txn(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE0001, 1'b0, "lw20");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst.vld", 32'(rsp_valid), 32'd0);
    check("mrst.rd",  rsp_rdata, 32'd0);
    check("mrst.err", 32'(rsp_err), 32'd0);
    check("mrst.rdy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("mrst.vld2", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    txn(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE0001, 1'b0, "lw20post");

    // LATENCY=3 streaming with valid/ready held high.
    st_we[0] = 1'b1; st_addr[0] = 32'h40; st_wd[0] = 32'hA0; st_exp[0] = 32'h0;
    st_we[1] = 1'b1; st_addr[1] = 32'h44; st_wd[1] = 32'hB1; st_exp[1] = 32'h0;
    st_we[2] = 1'b1; st_addr[2] = 32'h48; st_wd[2] = 32'hC2; st_exp[2] = 32'h0;
    st_we[3] = 1'b0; st_addr[3] = 32'h40; st_wd[3] = 32'h0;  st_exp[3] = 32'hA0;
    st_we[4] = 1'b0; st_addr[4] = 32'h44; st_wd[4] = 32'h0;  st_exp[4] = 32'hB1;
    st_we[5] = 1'b0; st_addr[5] = 32'h48; st_wd[5] = 32'h0;  st_exp[5] = 32'hC2;
    begin
      int sidx, ridx, cyc, last_acc;
      logic acc;
      sidx = 0; ridx = 0; cyc = 0; last_acc = -1;
      s_rsp_ready = 1'b1;
      s_req_valid = 1'b1; s_req_we = st_we[0]; s_req_addr = st_addr[0]; s_req_wdata = st_wd[0];
      while ((sidx < 6 || ridx < 6) && cyc < 100) begin
        acc = s_req_ready && s_req_valid;
        if (s_rsp_valid) begin
          check("strm.rd", s_rsp_rdata, st_exp[ridx]);
          ridx++;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          if (last_acc >= 0) check("strm.gap", 32'(cyc - last_acc), 32'd4);
          last_acc = cyc;
          sidx++;
          if (sidx < 6) begin
            s_req_we = st_we[sidx]; s_req_addr = st_addr[sidx]; s_req_wdata = st_wd[sidx];
          end else begin
            s_req_valid = 1'b0;
          end
        end
      end
      check("strm.nacc", 32'(sidx), 32'd6);
      check("strm.nrsp", 32'(ridx), 32'd6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, request address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width (fixed 32 for byte/half lane logic).
REQ-003 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words.
REQ-004 SHALL have parameter LATENCY, default 2, range 1..15, edges from request accept to rsp_valid.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  initiator request present.
REQ-008 SHALL have port req_ready  output  1  responder can accept a request.
REQ-009 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-011 SHALL have port req_addr  input  AWIDTH  byte address.
REQ-012 SHALL have port req_wdata  input  DWIDTH  store data, low-order lanes used for B/H.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-015 SHALL have port rsp_rdata  output  DWIDTH  load result, extended per funct3; 0 for stores.
REQ-016 SHALL have port rsp_err  output  1  access fault flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE and not in reset.
REQ-018 SHALL accept a request on an edge with req_valid&&req_ready, latching we, funct3, addr, wdata.
REQ-019 SHALL, on accept, go to RESP if LATENCY=1, else to WAIT with down-counter loaded LATENCY-1.
REQ-020 SHALL in WAIT decrement the counter each edge and enter RESP on the edge where it reaches 1 to 0 transition, giving rsp_valid exactly LATENCY edges after accept.
REQ-021 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE.
REQ-022 SHALL ignore req_valid outside IDLE; at most one transaction outstanding; max throughput one per LATENCY+1 cycles.
REQ-023 SHALL commit stores on the edge entering RESP, byte-enables from addr[1:0]/funct3: SB one lane, SH lanes addr[1]*2..+1, SW all four.
REQ-024 SHALL read load data on the edge entering RESP; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-025 SHALL treat load funct3 011/110/111 and store funct3 >= 011 as faults.
REQ-026 SHALL on a fault perform no write, return rsp_rdata=0, rsp_err=1 (macro enabled).
REQ-027 SHALL use word index addr[log2(DEPTH)+1:2] for array access.

Reset
REQ-028 SHALL on rst asynchronously force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0 while rst held.
REQ-029 SHALL discard any in-flight transaction on reset; a store not yet committed SHALL not be written.
REQ-030 SHALL not reset memory array contents.

Configuration
REQ-031 SHALL support macro DMEM_RESP_ERR_EN: defined -> misalignment (H with addr[0]=1, W with addr[1:0]!=0), out-of-range (word index >= DEPTH) and illegal funct3 flagged per REQ-026.
REQ-032 SHALL, without DMEM_RESP_ERR_EN, tie rsp_err to 0, ignore misaligned low address bits (H uses addr[1], W uses word), wrap index modulo DEPTH, treat illegal funct3 as W.

Verification
REQ-033 SHALL cover: LATENCY=2, SW 0xDEADBEEF @0x10 then LW @0x10 -> rsp_valid exactly 2 edges after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: SB 0x80 @0x13 over zeroed word, LB @0x13 -> 0xFFFFFF80, LBU -> 0x00000080, LW @0x10 -> 0x80000000.
REQ-035 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready 0, concurrent req_valid not accepted.
REQ-036 SHALL cover: LW @0x2 with macro -> err 1, rdata 0; without macro -> word @0x0 returned, err 0.
REQ-037 SHALL cover: rst pulsed in WAIT of SW 0x1234 @0x20 -> outputs 0 immediately; later LW @0x20 returns prior value.
REQ-038 SHALL cover: req_valid and rsp_ready held 1, LATENCY=3 -> accepts every 4 cycles, responses in order.
